// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack bus between the MEM stage and data memory
//
// Signals:
//   dmem_req    master->slave  request, held until ack or abort
//   dmem_we     master->slave  1 = write, 0 = read; valid while dmem_req
//   dmem_addr   master->slave  word-aligned address, stable while dmem_req
//   dmem_wdata  master->slave  store data, stable while dmem_req
//   dmem_ack    slave->master  completion, sampled on the pipeline's negedge
//   dmem_rdata  slave->master  load data, valid when dmem_ack=1
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: load/store req/ack transaction, upstream stall, write-back select
//
// Ports:
//   clock              pipeline clock; all state updates on its falling edge
//   reset_n            asynchronous active-low reset
//   ALUResult          load/store address, or pass-through result
//   memRead/memWrite   load / store request (read wins if both set)
//   memToReg           1: write back load data, 0: write back the address
//   registerFileDataB  store data
//   registerFileWrite  destination register index
//   dmem               data-memory bus (master side)
//   stall              combinational freeze of IF..EX/MEM
//   wb_valid           one-edge pulse qualifying wb_data/wb_reg
//   wb_data/wb_reg     write-back value and register index
//   misalign_err       one-edge pulse on an access with ALUResult[1:0]!=0
//   bus_error          sticky flag: memory never acknowledged within TIMEOUT edges
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [31:0]         ALUResult,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic                memToReg,
    input  logic [31:0]         registerFileDataB,
    input  logic [3:0]          registerFileWrite,
    mem_access_if.master        dmem,
    output logic                stall,
    output logic                wb_valid,
    output logic [31:0]         wb_data,
    output logic [3:0]          wb_reg,
    output logic                misalign_err,
    output logic                bus_error
);

    // Counter only has to reach TIMEOUT-1.
    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_alu;
    logic [31:0]       r_wdata;
    logic [3:0]        r_reg;
    logic              r_m2r;
    logic              r_wb_valid;
    logic [31:0]       r_wb_data;
    logic [3:0]        r_wb_reg;
    logic              r_misalign;
    logic              r_bus_err;

    logic w_access;
    logic w_aligned;
    logic w_last;

    assign w_access  = memRead | memWrite;
    assign w_aligned = (ALUResult[1:0] == 2'b00);
    assign w_last    = (r_cnt == CNT_LAST);

    // Stall drops in the ack/abort cycle so upstream advances on the same edge
    // the FSM returns to IDLE. Held low while reset is asserted.
    assign stall = reset_n &
                   (((r_state == S_IDLE) & w_access & w_aligned) |
                    ((r_state == S_WAIT) & ~dmem.dmem_ack & ~w_last));

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_alu      <= '0;
            r_wdata    <= '0;
            r_reg      <= '0;
            r_m2r      <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_reg   <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            // Pulses default low; set below only on the edge they belong to.
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_access) begin
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= ALUResult;
                        r_wb_reg   <= registerFileWrite;
                    end else if (!w_aligned) begin
                        r_misalign <= 1'b1;
                    end else begin
                        r_addr  <= ALUResult[ADDR_W-1:0];
                        r_alu   <= ALUResult;
                        r_wdata <= registerFileDataB;
                        r_we    <= memWrite & ~memRead;
                        r_reg   <= registerFileWrite;
                        r_m2r   <= memToReg;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                        if (!r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= r_m2r ? dmem.dmem_rdata : r_alu;
                            r_wb_reg   <= r_reg;
                        end
                    end else if (w_last) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;

    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_reg       = r_wb_reg;
    assign misalign_err = r_misalign;
    assign bus_error    = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ALUResult;
    logic        memRead, memWrite, memToReg;
    logic [31:0] registerFileDataB;
    logic [3:0]  registerFileWrite;
    logic        stall, wb_valid, misalign_err, bus_error;
    logic [31:0] wb_data;
    logic [3:0]  wb_reg;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_if #(.ADDR_W(32)) u_if ();

    mem_access #(.ADDR_W(32), .TIMEOUT(16)) u_dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ALUResult         (ALUResult),
        .memRead           (memRead),
        .memWrite          (memWrite),
        .memToReg          (memToReg),
        .registerFileDataB (registerFileDataB),
        .registerFileWrite (registerFileWrite),
        .dmem              (u_if.master),
        .stall             (stall),
        .wb_valid          (wb_valid),
        .wb_data           (wb_data),
        .wb_reg            (wb_reg),
        .misalign_err      (misalign_err),
        .bus_error         (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic [31:0] datab;
        logic [3:0]  rg;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_reg;
        logic        e_mis;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic rd, input logic wr,
                         input logic m2r, input logic [31:0] b, input logic [3:0] rg);
        ALUResult         = alu;
        memRead           = rd;
        memWrite          = wr;
        memToReg          = m2r;
        registerFileDataB = b;
        registerFileWrite = rg;
    endtask

    task automatic nop();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    endtask

    // Advance one active (falling) edge and settle.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,        4'd5,  1'b0, 1'b1, 32'h12345678, 4'd5,  1'b0};
        vecs[1] = '{32'h00000102, 1'b1, 1'b0, 1'b1, 32'h0,        4'd2,  1'b0, 1'b0, 32'h0,        4'd0,  1'b1};
        vecs[2] = '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0,        4'd15, 1'b0, 1'b1, 32'hFFFFFFFF, 4'd15, 1'b0};
        vecs[3] = '{32'h00000041, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 4'd1,  1'b0, 1'b0, 32'h0,        4'd0,  1'b1};
        vecs[4] = '{32'h00000003, 1'b1, 1'b1, 1'b0, 32'h0,        4'd6,  1'b0, 1'b0, 32'h0,        4'd0,  1'b1};
        vecs[5] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 32'h0,        4'd0,  1'b0, 1'b1, 32'h00000000, 4'd0,  1'b0};

        nop();
        u_if.dmem_ack   = 1'b0;
        u_if.dmem_rdata = 32'h0;

        // Reset state
        #2;
        chk("rst_req",      {31'h0, u_if.dmem_req}, 32'h0);
        chk("rst_we",       {31'h0, u_if.dmem_we},  32'h0);
        chk("rst_addr",     u_if.dmem_addr,         32'h0);
        chk("rst_wdata",    u_if.dmem_wdata,        32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid},      32'h0);
        chk("rst_wb_data",  wb_data,                32'h0);
        chk("rst_mis",      {31'h0, misalign_err},  32'h0);
        chk("rst_bus_err",  {31'h0, bus_error},     32'h0);
        chk("rst_stall",    {31'h0, stall},         32'h0);
        step();
        reset_n = 1'b1;

        // Single-edge vectors: pass-through and misaligned accesses
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].alu, vecs[i].rd, vecs[i].wr, vecs[i].m2r, vecs[i].datab, vecs[i].rg);
            @(posedge clock);
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].e_stall});
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, wb_valid},     {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_mis", i),   {31'h0, misalign_err}, {31'h0, vecs[i].e_mis});
            chk($sformatf("v%0d_req", i),   {31'h0, u_if.dmem_req}, 32'h0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_data", i), wb_data,             vecs[i].e_data);
                chk($sformatf("v%0d_reg", i),  {28'h0, wb_reg},     {28'h0, vecs[i].e_reg});
            end
        end

        // Load, ack three edges after issue, memToReg=1
        drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h0, 4'd3);
        @(posedge clock);
        chk("ld_stall_idle", {31'h0, stall}, 32'h1);
        step();
        chk("ld_req",  {31'h0, u_if.dmem_req}, 32'h1);
        chk("ld_we",   {31'h0, u_if.dmem_we},  32'h0);
        chk("ld_addr", u_if.dmem_addr,         32'h100);
        step();
        chk("ld_req_w1",   {31'h0, u_if.dmem_req}, 32'h1);
        chk("ld_stall_w1", {31'h0, stall},         32'h1);
        step();
        chk("ld_req_w2",   {31'h0, u_if.dmem_req}, 32'h1);
        chk("ld_addr_w2",  u_if.dmem_addr,         32'h100);
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_ack", {31'h0, stall}, 32'h0);
        step();
        u_if.dmem_ack = 1'b0;
        nop();
        chk("ld_req_done", {31'h0, u_if.dmem_req}, 32'h0);
        chk("ld_valid",    {31'h0, wb_valid},      32'h1);
        chk("ld_data",     wb_data,                32'hDEADBEEF);
        chk("ld_reg",      {28'h0, wb_reg},        32'd3);
        step();

        // Load with memToReg=0 writes back the address; ack on first WAIT edge
        drive(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 4'd4);
        step();
        u_if.dmem_ack   = 1'b1;
        u_if.dmem_rdata = 32'h11111111;
        step();
        u_if.dmem_ack = 1'b0;
        nop();
        chk("ld2_valid", {31'h0, wb_valid}, 32'h1);
        chk("ld2_data",  wb_data,           32'h200);
        chk("ld2_reg",   {28'h0, wb_reg},   32'd4);
        step();

        // Store, ack next cycle
        drive(32'h40, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 4'd7);
        step();
        chk("st_req",   {31'h0, u_if.dmem_req}, 32'h1);
        chk("st_we",    {31'h0, u_if.dmem_we},  32'h1);
        chk("st_addr",  u_if.dmem_addr,         32'h40);
        chk("st_wdata", u_if.dmem_wdata,        32'hCAFEF00D);
        u_if.dmem_ack = 1'b1;
        step();
        u_if.dmem_ack = 1'b0;
        nop();
        chk("st_req_done", {31'h0, u_if.dmem_req}, 32'h0);
        chk("st_valid",    {31'h0, wb_valid},      32'h0);
        step();

        // Timeout: no ack for 16 WAIT edges
        drive(32'h80, 1'b1, 1'b0, 1'b1, 32'h0, 4'd8);
        step();
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("to_req_%0d", k), {31'h0, u_if.dmem_req}, 32'h1);
        end
        chk("to_stall_last", {31'h0, stall}, 32'h0);
        step();
        nop();
        chk("to_req_drop", {31'h0, u_if.dmem_req}, 32'h0);
        chk("to_bus_err",  {31'h0, bus_error},     32'h1);
        chk("to_valid",    {31'h0, wb_valid},      32'h0);

        // Ack seen in IDLE is ignored; bus_error stays sticky
        drive(32'h0BADF00D, 1'b0, 1'b0, 1'b0, 32'h0, 4'd10);
        u_if.dmem_ack = 1'b1;
        step();
        u_if.dmem_ack = 1'b0;
        chk("idle_ack_valid", {31'h0, wb_valid},      32'h1);
        chk("idle_ack_data",  wb_data,                32'h0BADF00D);
        chk("idle_ack_req",   {31'h0, u_if.dmem_req}, 32'h0);
        chk("to_bus_sticky",  {31'h0, bus_error},     32'h1);

        // Reset two edges into a load
        drive(32'h100, 1'b1, 1'b0, 1'b1, 32'h0, 4'd3);
        step();
        step();
        chk("rw_req_before", {31'h0, u_if.dmem_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_req",     {31'h0, u_if.dmem_req}, 32'h0);
        chk("rw_stall",   {31'h0, stall},         32'h0);
        chk("rw_bus_err", {31'h0, bus_error},     32'h0);
        nop();
        step();
        reset_n = 1'b1;
        drive(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h0, 4'd9);
        step();
        chk("rw_pass_valid", {31'h0, wb_valid}, 32'h1);
        chk("rw_pass_data",  wb_data,           32'hA5A5A5A5);
        chk("rw_pass_reg",   {28'h0, wb_reg},   32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
